shift_reg_serializer_ctrl: RTL and testbench

//  Upstream controller for the 8-bit load/shift register. Accepts parallel words on a valid/ready handshake
//  and drives the register's I / load_enable / shift_left_right inputs. Reads the register output q back and

---
 rtl/shift_reg_pkg.sv | 22 ++
 rtl/shift_reg_serializer_ctrl_bit_period_counter.sv | 39 +++
 rtl/shift_reg_serializer_ctrl.sv | 145 ++++++++++++++
 tb/tb_shift_reg_serializer_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register serializer controller.
//  - state_e : controller FSM encoding (IDLE, BIT, PAR, DONE)
//  - SR_LOAD / SR_SHIFT  : values for the register's load_enable input
//  - DIR_LEFT / DIR_RIGHT: values for the register's shift_left_right input
//  - DEFAULT_WIDTH       : default data word width
package shift_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIT  = 2'd1,
    PAR  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic SR_LOAD   = 1'b0;
  localparam logic SR_SHIFT  = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_reg_serializer_ctrl_bit_period_counter.sv
// bit_period_counter: counts 0..CLKS_PER_BIT-1 while enabled and wraps to 0.
// Held at 0 while disabled, so every bit period starts from a clean count.
// Ports:
//  clk      in  rising-edge clock
//  reset_n  in  asynchronous active-low reset
//  enable   in  count while high, clear to 0 while low
//  last     out high when the count equals CLKS_PER_BIT-1
module bit_period_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic last
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // With CLKS_PER_BIT=1 the count is permanently 0, so last is always high.
  assign last = (cnt_q == LAST_CNT);

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable)   cnt_d = '0;
    else if (last) cnt_d = '0;
    else           cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/shift_reg_serializer_ctrl.sv
// shift_reg_serializer_ctrl: upstream controller for an external load/shift register.
// Accepts a parallel word on a valid/ready handshake, loads it into the register, then
// shifts it out one bit per CLKS_PER_BIT clocks, presenting the bit read back from q.
// The register has no hold mode, so whenever no load or shift is wanted the controller
// drives load with sr_data=sr_q (recirculate).
// Optional feature: define SERIALIZER_PARITY_EN to append an even-parity bit (PAR state).
// Ports:
//  clk, reset_n          clock and asynchronous active-low reset (shared with the register)
//  in_data/in_valid      parallel word and its valid; in_ready high only in IDLE
//  lsb_first             0 = MSB-first (left shift), 1 = LSB-first (right shift), sampled at accept
//  sr_q                  register output, read back
//  sr_data               register parallel input I
//  sr_load_enable        0 = load, 1 = shift
//  sr_shift_dir          0 = left, 1 = right
//  serial_out            current serial bit, 1 when idle
//  serial_valid          serial_out carries a data or parity bit
//  done                  one-cycle pulse after the last bit period
module shift_reg_serializer_ctrl
  import shift_reg_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             lsb_first,
  input  logic [WIDTH-1:0] sr_q,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_load_enable,
  output logic             sr_shift_dir,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  state_e         state_q, state_d;
  logic           dir_q, dir_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           period_last;
  logic           period_en;
`ifdef SERIALIZER_PARITY_EN
  logic           parity_q, parity_d;
`endif

  assign period_en    = (state_q == BIT) || (state_q == PAR);
  assign sr_shift_dir = dir_q;

  bit_period_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_period (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (period_en),
    .last   (period_last)
  );

  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    bit_cnt_d      = bit_cnt_q;
`ifdef SERIALIZER_PARITY_EN
    parity_d       = parity_q;
`endif
    in_ready       = 1'b0;
    sr_data        = sr_q;
    sr_load_enable = SR_LOAD;
    serial_out     = 1'b1;
    serial_valid   = 1'b0;
    done           = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sr_data   = in_data;
          dir_d     = lsb_first;
          bit_cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
          parity_d  = ^in_data;
`endif
          state_d   = BIT;
        end
      end

      BIT: begin
        serial_valid = 1'b1;
        // The outgoing bit is the one at the end the register shifts away from.
        serial_out   = (dir_q == DIR_RIGHT) ? sr_q[0] : sr_q[WIDTH-1];
        if (period_last) begin
          sr_load_enable = SR_SHIFT;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
            state_d   = PAR;
`else
            state_d   = DONE;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

`ifdef SERIALIZER_PARITY_EN
      PAR: begin
        serial_valid = 1'b1;
        serial_out   = parity_q;
        if (period_last) state_d = DONE;
      end
`endif

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dir_q     <= DIR_LEFT;
      bit_cnt_q <= '0;
`ifdef SERIALIZER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_reg_serializer_ctrl.sv
// Directed bench for shift_reg_serializer_ctrl. Two controller instances (CLKS_PER_BIT=4
// and CLKS_PER_BIT=1) each drive their own behavioural 8-bit load/shift register.
// `sel` picks which instance the stimulus and observation tasks talk to.
module tb_shift_reg_serializer_ctrl;

  localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         lsb_first;
  logic         sel;

  int n_checks = 0;
  int n_errors = 0;

  // Instance 0: CLKS_PER_BIT = 4
  logic         v0_in_valid, v0_in_ready, v0_le, v0_dir, v0_so, v0_sv, v0_done;
  logic [W-1:0] v0_sr_data, v0_q;
  // Instance 1: CLKS_PER_BIT = 1
  logic         v1_in_valid, v1_in_ready, v1_le, v1_dir, v1_so, v1_sv, v1_done;
  logic [W-1:0] v1_sr_data, v1_q;

  assign v0_in_valid = in_valid & ~sel;
  assign v1_in_valid = in_valid & sel;

  always #5 clk = ~clk;

  shift_reg_serializer_ctrl #(.WIDTH(W), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(v0_in_valid),
    .in_ready(v0_in_ready), .lsb_first(lsb_first), .sr_q(v0_q), .sr_data(v0_sr_data),
    .sr_load_enable(v0_le), .sr_shift_dir(v0_dir), .serial_out(v0_so),
    .serial_valid(v0_sv), .done(v0_done)
  );

  shift_reg_serializer_ctrl #(.WIDTH(W), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(v1_in_valid),
    .in_ready(v1_in_ready), .lsb_first(lsb_first), .sr_q(v1_q), .sr_data(v1_sr_data),
    .sr_load_enable(v1_le), .sr_shift_dir(v1_dir), .serial_out(v1_so),
    .serial_valid(v1_sv), .done(v1_done)
  );

  // Behavioural load/shift registers: load_enable=0 loads I, 1 shifts with zero fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    v0_q <= '0;
    else if (!v0_le) v0_q <= v0_sr_data;
    else if (v0_dir) v0_q <= {1'b0, v0_q[W-1:1]};
    else             v0_q <= {v0_q[W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    v1_q <= '0;
    else if (!v1_le) v1_q <= v1_sr_data;
    else if (v1_dir) v1_q <= {1'b0, v1_q[W-1:1]};
    else             v1_q <= {v1_q[W-2:0], 1'b0};
  end

  // Observed view of the selected instance.
  logic         o_ready, o_le, o_dir, o_so, o_sv, o_done;
  logic [W-1:0] o_sr_data, o_q;
  assign o_ready   = sel ? v1_in_ready : v0_in_ready;
  assign o_le      = sel ? v1_le       : v0_le;
  assign o_dir     = sel ? v1_dir      : v0_dir;
  assign o_so      = sel ? v1_so       : v0_so;
  assign o_sv      = sel ? v1_sv       : v0_sv;
  assign o_done    = sel ? v1_done     : v0_done;
  assign o_sr_data = sel ? v1_sr_data  : v0_sr_data;
  assign o_q       = sel ? v1_q        : v0_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected emitted stream, first bit in the MSB; parity (when built in) appended at bit 0.
  function automatic logic [8:0] exp_stream(input logic [W-1:0] d, input logic lsb);
    logic [W-1:0] o;
    for (int i = 0; i < W; i++) o[W-1-i] = lsb ? d[i] : d[W-1-i];
    if (PAR_BITS == 1) return {o, ^d};
    return {1'b0, o};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, ".in_ready"},     32'(o_ready), 32'd1);
    check({tag, ".serial_valid"}, 32'(o_sv),    32'd0);
    check({tag, ".done"},         32'(o_done),  32'd0);
    check({tag, ".serial_out"},   32'(o_so),    32'd1);
    check({tag, ".load_enable"},  32'(o_le),    32'd0);
    check({tag, ".sr_data"},      32'(o_sr_data), 32'(o_q));
  endtask

  // Presents a word for one edge; with hold=1 in_valid stays high afterwards.
  task automatic accept(input string tag, input logic [W-1:0] d, input logic lsb, input bit hold);
    check({tag, ".ready_before"}, 32'(o_ready), 32'd1);
    in_data   = d;
    lsb_first = lsb;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  // Called one cycle after accept; follows the frame to done and one cycle beyond.
  task automatic collect(input string tag, input int cpb, input logic lsb, input logic [8:0] exp_bits);
    int       v = 0;
    logic [8:0] bits = '0;
    logic     cur = 1'b0;
    bit       hold_ok = 1'b1, rdy_ok = 1'b1, dir_ok = 1'b1, got_done = 1'b0;
    check({tag, ".valid_rise"}, 32'(o_sv), 32'd1);
    for (int c = 0; c < 200; c++) begin
      if (o_done) begin
        got_done = 1'b1;
        break;
      end
      if (o_sv) begin
        if (v % cpb == 0) begin
          cur  = o_so;
          bits = {bits[7:0], cur};
        end else if (o_so !== cur) begin
          hold_ok = 1'b0;
        end
        if (o_ready !== 1'b0) rdy_ok = 1'b0;
        if (o_dir !== lsb)    dir_ok = 1'b0;
        v++;
      end
      @(posedge clk); #1;
    end
    check({tag, ".done_seen"},    32'(got_done), 32'd1);
    check({tag, ".valid_cycles"}, 32'(v),        32'((W + PAR_BITS) * cpb));
    check({tag, ".stream"},       32'(bits),     32'(exp_bits));
    check({tag, ".bit_hold"},     32'(hold_ok),  32'd1);
    check({tag, ".ready_low"},    32'(rdy_ok),   32'd1);
    check({tag, ".shift_dir"},    32'(dir_ok),   32'd1);
    check({tag, ".q_at_done"},    32'(o_q),      32'd0);
    check({tag, ".done_valid"},   32'(o_sv),     32'd0);
    check({tag, ".done_so"},      32'(o_so),     32'd1);
    check({tag, ".done_ready"},   32'(o_ready),  32'd0);
    @(posedge clk); #1;
    check({tag, ".done_pulse1"},  32'(o_done),   32'd0);
    check({tag, ".ready_back"},   32'(o_ready),  32'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    lsb_first = 1'b0;
    sel       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset.dir", 32'(o_dir), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("idle_hold");

    // 1: MSB-first A5
    accept("t1", 8'hA5, 1'b0, 1'b0);
    collect("t1", 4, 1'b0, exp_stream(8'hA5, 1'b0));

    // 2: LSB-first A5
    accept("t2", 8'hA5, 1'b1, 1'b0);
    collect("t2", 4, 1'b1, exp_stream(8'hA5, 1'b1));

    // 3: back-to-back with in_valid held high; second word must wait for done
    accept("t3a", 8'hFF, 1'b0, 1'b1);
    in_data = 8'h01;
    collect("t3a", 4, 1'b0, exp_stream(8'hFF, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect("t3b", 4, 1'b0, exp_stream(8'h01, 1'b0));

    // 4: reset 10 cycles into a frame, then a clean frame
    accept("t4", 8'hA5, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("t4.reset_now");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t4.no_done", 32'(o_done), 32'd0);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("t4.no_done_after", 32'(o_done), 32'd0);
    check_idle_outputs("t4.idle");
    accept("t4b", 8'h1E, 1'b1, 1'b0);
    collect("t4b", 4, 1'b1, exp_stream(8'h1E, 1'b1));

    // 5: CLKS_PER_BIT=1 instance, inputs changed mid-frame
    sel = 1'b1;
    #1;
    check_idle_outputs("t5.idle");
    accept("t5", 8'h81, 1'b0, 1'b0);
    in_data   = 8'h00;
    lsb_first = 1'b1;
    collect("t5", 1, 1'b0, exp_stream(8'h81, 1'b0));
    sel = 1'b0;
    #1;

    // 6: word with odd population; parity bit 1 appended when parity is built in
    accept("t6", 8'h07, 1'b0, 1'b0);
    collect("t6", 4, 1'b0, exp_stream(8'h07, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
